// File: rtl/stream_mux4.sv
// stream_mux4: packet-atomic 4:1 valid/ready stream merge, round-robin.
// Ports: clk, rst_n, in_valid/in_data/in_last/in_ready (per channel),
//        out_valid/out_data/out_last/out_sel/out_ready (merged stream).
module stream_mux4 #(
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [3:0]          in_valid,
   input  logic [4*DATA_W-1:0] in_data,
   input  logic [3:0]          in_last,
   output logic [3:0]          in_ready,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_last,
   output logic [1:0]          out_sel,
   input  logic                out_ready
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0] state;
   logic [1:0] ptr;
   logic [1:0] lck;

   logic       load_en;
   logic [1:0] gnt;
   logic       gnt_ok;
   logic       xfer;
   logic [1:0] idx;

   assign load_en = !out_valid || out_ready;

   // Rotating priority search starting at ptr; a locked packet
   // owns the output until its last beat.
   always_comb begin
      gnt    = 2'd0;
      gnt_ok = 1'b0;
      idx    = 2'd0;
      if (state == LOCKED) begin
         gnt    = lck;
         gnt_ok = 1'b1;
      end else begin
         for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (in_valid[idx]) begin
               gnt    = idx;
               gnt_ok = 1'b1;
            end
         end
      end
   end

   // Reset gating keeps in_ready low while rst_n is held.
   always_comb begin
      in_ready = 4'b0000;
      if (rst_n && gnt_ok && load_en)
         in_ready[gnt] = 1'b1;
   end

   assign xfer = |(in_valid & in_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         lck       <= 2'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sel   <= 2'd0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gnt*DATA_W +: DATA_W];
            out_last  <= in_last[gnt];
            out_sel   <= gnt;
            if (in_last[gnt]) begin
               ptr   <= gnt + 2'd1;
               state <= IDLE;
            end else begin
               lck   <= gnt;
               state <= LOCKED;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/stream_mux4.md
STREAM_MUX4 -- requirements
Module: stream_mux4

Interface
REQ-001 Parameter: DATA_W, default 8, width of each data channel in bits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  4  per-channel beat valid; bit i belongs to channel i.
REQ-005 in_data  input  4*DATA_W  channel i data at bits [i*DATA_W +: DATA_W].
REQ-006 in_last  input  4  per-channel last-beat-of-packet flag.
REQ-007 in_ready  output  4  per-channel accept; at most one bit set in any cycle.
REQ-008 out_valid  output  1  registered output beat valid.
REQ-009 out_data  output  DATA_W  registered output data.
REQ-010 out_last  output  1  registered last flag of the output beat.
REQ-011 out_sel  output  2  index of the source channel of the output beat.
REQ-012 out_ready  input  1  downstream accept.

Function
REQ-013 The block SHALL merge four valid/ready streams into one stream, packet-atomic, with round-robin arbitration. It is the inverse of the 1-to-4 demultiplexer.
REQ-014 A transfer on channel i SHALL occur when in_valid[i] && in_ready[i]. A transfer on the output SHALL occur when out_valid && out_ready.
REQ-015 load_en SHALL equal !out_valid || out_ready. in_ready SHALL be combinational from state, in_valid and out_ready.
REQ-016 The FSM SHALL have two states, IDLE and LOCKED, and SHALL hold a 2-bit round-robin pointer ptr and a 2-bit lock channel lck.
REQ-017 In IDLE, grant g SHALL be the first channel with in_valid set, searched in order ptr, ptr+1, ptr+2, ptr+3 (mod 4). in_ready[g] SHALL equal load_en. All other in_ready bits SHALL be 0. With no in_valid set, in_ready SHALL be 0.
REQ-018 IDLE transfer with in_last[g]=1: ptr SHALL become g+1 (mod 4), and the FSM SHALL stay in IDLE.
REQ-019 IDLE transfer with in_last[g]=0: lck SHALL become g, and the FSM SHALL go to LOCKED.
REQ-020 In LOCKED, only channel lck SHALL be granted: in_ready[lck] equals load_en, and other channels are ignored even if valid.
REQ-021 LOCKED transfer with in_last[lck]=1: ptr SHALL become lck+1 (mod 4), and the FSM SHALL return to IDLE.
REQ-022 On any input transfer: out_data, out_last and out_sel SHALL load from the granted channel on the next edge, and out_valid SHALL be 1.
REQ-023 On an output transfer without a simultaneous input transfer, out_valid SHALL become 0. Data registers SHALL keep their values.
REQ-024 When out_valid=1 and out_ready=0, out_data, out_last and out_sel SHALL be held stable, and in_ready SHALL be 0.
REQ-025 Latency SHALL be 1 cycle from input transfer to out_valid. Sustained throughput SHALL be 1 beat/cycle when out_ready is held at 1.
REQ-026 No beat SHALL be dropped or duplicated. Beats of different packets SHALL never interleave on the output.
REQ-027 An unselected in_valid SHALL have no effect on state.

Reset
REQ-028 While rst_n=0, the outputs SHALL be: out_valid=0, out_data=0, out_last=0, out_sel=0, in_ready=0.
REQ-029 While rst_n=0, internal state SHALL be: state=IDLE, ptr=0, lck=0.
REQ-030 Reset asserted mid-packet SHALL abandon the lock and discard any held output beat. After release, arbitration SHALL restart from channel 0.
REQ-031 The first grant SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-032 Single beat: ch2 valid, data=0xA5, last=1, out_ready=1 → next cycle out_valid=1, out_data=0xA5, out_sel=2, out_last=1; ptr becomes 3.
REQ-033 Round robin: all four channels valid with single-beat packets, out_ready=1 → out_sel sequence 0,1,2,3,0, one per cycle.
REQ-034 Packet lock: ch1 sends a 3-beat packet (0x10, 0x11, 0x12 with last) while ch0 and ch3 are valid → output is 0x10, 0x11, 0x12 from ch1, then ch3 is granted; in_ready[0] and in_ready[3] stay 0 during the packet.
REQ-035 Backpressure: out_ready=0 for 4 cycles with a beat held → out_data is stable, in_ready=0; on out_ready=1, the next beat loads in the same cycle.
REQ-036 Reset mid-packet: ch2 locked after 1 of 3 beats, rst_n pulsed low → all outputs 0; after release, ch0 and ch2 both valid → ch0 is granted first.
REQ-037 Idle drain: single beat accepted, then no input and out_ready=1 → out_valid drops to 0 the cycle after the output transfer.
